// File: rtl/l2_output_encoder_if.sv
// Outbound L2 channels: coherence req/rsp, CPU read response, L1 inval.
// master = encoder side (drives valid/payload), slave = consumer side.
interface l2_output_encoder_if #(
    parameter int MSG_W  = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int ID_W   = 4
);
    logic              l2_req_out_valid_int;
    logic              l2_req_out_ready_int;
    logic [MSG_W-1:0]  l2_req_out_msg;
    logic [ADDR_W-1:0] l2_req_out_addr;
    logic [LINE_W-1:0] l2_req_out_line;

    logic              l2_rsp_out_valid_int;
    logic              l2_rsp_out_ready_int;
    logic [MSG_W-1:0]  l2_rsp_out_msg;
    logic [ID_W-1:0]   l2_rsp_out_id;
    logic [ADDR_W-1:0] l2_rsp_out_addr;
    logic [LINE_W-1:0] l2_rsp_out_line;

    logic              l2_rd_rsp_valid_int;
    logic              l2_rd_rsp_ready_int;
    logic [LINE_W-1:0] l2_rd_rsp_line;

    logic              l2_inval_valid_int;
    logic              l2_inval_ready_int;
    logic [ADDR_W-1:0] l2_inval_addr;

    modport master (
        output l2_req_out_valid_int, l2_req_out_msg,
        output l2_req_out_addr, l2_req_out_line,
        input  l2_req_out_ready_int,
        output l2_rsp_out_valid_int, l2_rsp_out_msg,
        output l2_rsp_out_id, l2_rsp_out_addr, l2_rsp_out_line,
        input  l2_rsp_out_ready_int,
        output l2_rd_rsp_valid_int, l2_rd_rsp_line,
        input  l2_rd_rsp_ready_int,
        output l2_inval_valid_int, l2_inval_addr,
        input  l2_inval_ready_int
    );

    modport slave (
        input  l2_req_out_valid_int, l2_req_out_msg,
        input  l2_req_out_addr, l2_req_out_line,
        output l2_req_out_ready_int,
        input  l2_rsp_out_valid_int, l2_rsp_out_msg,
        input  l2_rsp_out_id, l2_rsp_out_addr, l2_rsp_out_line,
        output l2_rsp_out_ready_int,
        input  l2_rd_rsp_valid_int, l2_rd_rsp_line,
        output l2_rd_rsp_ready_int,
        input  l2_inval_valid_int, l2_inval_addr,
        output l2_inval_ready_int
    );
endinterface

// File: rtl/l2_output_encoder.sv
// L2 output encoder: registered holding slots for outbound channels,
// per-channel stall reporting and a drain handshake for flush.
module l2_output_encoder #(
    parameter int MSG_W  = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                send_req_out,
    input  logic [MSG_W-1:0]    req_out_msg_i,
    input  logic [ADDR_W-1:0]   req_out_addr_i,
    input  logic [LINE_W-1:0]   req_out_line_i,

    input  logic                send_rsp_out,
    input  logic [MSG_W-1:0]    rsp_out_msg_i,
    input  logic [ID_W-1:0]     rsp_out_id_i,
    input  logic [ADDR_W-1:0]   rsp_out_addr_i,
    input  logic [LINE_W-1:0]   rsp_out_line_i,

    input  logic                send_rd_rsp,
    input  logic [LINE_W-1:0]   rd_rsp_line_i,

    input  logic                send_inval,
    input  logic [ADDR_W-1:0]   inval_addr_i,

    l2_output_encoder_if.master out_if,

    output logic                req_out_stall,
    output logic                rsp_out_stall,
    output logic                rd_rsp_stall,
    output logic                inval_stall,

    input  logic                drain_req,
    output logic                drain_done,
    output logic                out_idle,
    output logic                overflow_err
);

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_DONE
    } drain_st_e;

    logic              req_full_q, req_full_d;
    logic [MSG_W-1:0]  req_msg_q, req_msg_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [LINE_W-1:0] req_line_q, req_line_d;

    logic              rsp_full_q, rsp_full_d;
    logic [MSG_W-1:0]  rsp_msg_q, rsp_msg_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [LINE_W-1:0] rsp_line_q, rsp_line_d;

    logic              rd_full_q, rd_full_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;

    logic [ADDR_W-1:0] inv_mem_q [2];
    logic [ADDR_W-1:0] inv_mem_d [2];
    logic              inv_wr_q, inv_wr_d;
    logic              inv_rd_q, inv_rd_d;
    logic [1:0]        inv_cnt_q, inv_cnt_d;

    logic              ovf_q, ovf_d;
    drain_st_e         dr_st_q, dr_st_d;

    logic req_acc, rsp_acc, rd_acc;
    logic req_fire, rsp_fire, rd_fire;
    logic inv_push, inv_pop, any_send;

    assign req_out_stall = req_full_q && !out_if.l2_req_out_ready_int;
    assign rsp_out_stall = rsp_full_q && !out_if.l2_rsp_out_ready_int;
    assign rd_rsp_stall  = rd_full_q && !out_if.l2_rd_rsp_ready_int;
    assign inval_stall   = (inv_cnt_q == 2'd2)
                        && !out_if.l2_inval_ready_int;

    assign req_fire = req_full_q && out_if.l2_req_out_ready_int;
    assign rsp_fire = rsp_full_q && out_if.l2_rsp_out_ready_int;
    assign rd_fire  = rd_full_q && out_if.l2_rd_rsp_ready_int;

    assign req_acc  = send_req_out && !req_out_stall;
    assign rsp_acc  = send_rsp_out && !rsp_out_stall;
    assign rd_acc   = send_rd_rsp && !rd_rsp_stall;
    assign inv_push = send_inval && !inval_stall;
    assign inv_pop  = (inv_cnt_q != 2'd0) && out_if.l2_inval_ready_int;

    assign any_send = send_req_out || send_rsp_out
                   || send_rd_rsp || send_inval;

    assign out_idle = !req_full_q && !rsp_full_q && !rd_full_q
                   && (inv_cnt_q == 2'd0);

    always_comb begin
        req_full_d = req_full_q;
        req_msg_d  = req_msg_q;
        req_addr_d = req_addr_q;
        req_line_d = req_line_q;
        if (req_acc) begin
            req_full_d = 1'b1;
            req_msg_d  = req_out_msg_i;
            req_addr_d = req_out_addr_i;
            req_line_d = req_out_line_i;
        end else if (req_fire) begin
            req_full_d = 1'b0;
        end
    end

    always_comb begin
        rsp_full_d = rsp_full_q;
        rsp_msg_d  = rsp_msg_q;
        rsp_id_d   = rsp_id_q;
        rsp_addr_d = rsp_addr_q;
        rsp_line_d = rsp_line_q;
        if (rsp_acc) begin
            rsp_full_d = 1'b1;
            rsp_msg_d  = rsp_out_msg_i;
            rsp_id_d   = rsp_out_id_i;
            rsp_addr_d = rsp_out_addr_i;
            rsp_line_d = rsp_out_line_i;
        end else if (rsp_fire) begin
            rsp_full_d = 1'b0;
        end
    end

    always_comb begin
        rd_full_d = rd_full_q;
        rd_line_d = rd_line_q;
        if (rd_acc) begin
            rd_full_d = 1'b1;
            rd_line_d = rd_rsp_line_i;
        end else if (rd_fire) begin
            rd_full_d = 1'b0;
        end
    end

    // A push at count 2 with a pop lands in the slot the head vacates.
    always_comb begin
        inv_mem_d = inv_mem_q;
        inv_wr_d  = inv_wr_q;
        inv_rd_d  = inv_rd_q;
        if (inv_push) begin
            inv_mem_d[inv_wr_q] = inval_addr_i;
            inv_wr_d = !inv_wr_q;
        end
        if (inv_pop) begin
            inv_rd_d = !inv_rd_q;
        end
        inv_cnt_d = inv_cnt_q + {1'b0, inv_push} - {1'b0, inv_pop};
    end

    always_comb begin
        ovf_d = ovf_q
             || (send_req_out && req_out_stall)
             || (send_rsp_out && rsp_out_stall)
             || (send_rd_rsp && rd_rsp_stall)
             || (send_inval && inval_stall);
    end

    always_comb begin
        dr_st_d    = dr_st_q;
        drain_done = 1'b0;
        unique case (dr_st_q)
            DR_IDLE: if (drain_req) dr_st_d = DR_WAIT;
            DR_WAIT: if (out_idle && !any_send) dr_st_d = DR_DONE;
            DR_DONE: begin
                drain_done = 1'b1;
                dr_st_d    = DR_IDLE;
            end
            default: dr_st_d = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_full_q <= 1'b0;
            req_msg_q  <= '0;
            req_addr_q <= '0;
            req_line_q <= '0;
            rsp_full_q <= 1'b0;
            rsp_msg_q  <= '0;
            rsp_id_q   <= '0;
            rsp_addr_q <= '0;
            rsp_line_q <= '0;
            rd_full_q  <= 1'b0;
            rd_line_q  <= '0;
            inv_mem_q[0] <= '0;
            inv_mem_q[1] <= '0;
            inv_wr_q   <= 1'b0;
            inv_rd_q   <= 1'b0;
            inv_cnt_q  <= 2'd0;
            ovf_q      <= 1'b0;
            dr_st_q    <= DR_IDLE;
        end else begin
            req_full_q <= req_full_d;
            req_msg_q  <= req_msg_d;
            req_addr_q <= req_addr_d;
            req_line_q <= req_line_d;
            rsp_full_q <= rsp_full_d;
            rsp_msg_q  <= rsp_msg_d;
            rsp_id_q   <= rsp_id_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_line_q <= rsp_line_d;
            rd_full_q  <= rd_full_d;
            rd_line_q  <= rd_line_d;
            inv_mem_q  <= inv_mem_d;
            inv_wr_q   <= inv_wr_d;
            inv_rd_q   <= inv_rd_d;
            inv_cnt_q  <= inv_cnt_d;
            ovf_q      <= ovf_d;
            dr_st_q    <= dr_st_d;
        end
    end

    assign overflow_err = ovf_q;

    assign out_if.l2_req_out_valid_int = req_full_q;
    assign out_if.l2_req_out_msg       = req_msg_q;
    assign out_if.l2_req_out_addr      = req_addr_q;
    assign out_if.l2_req_out_line      = req_line_q;

    assign out_if.l2_rsp_out_valid_int = rsp_full_q;
    assign out_if.l2_rsp_out_msg       = rsp_msg_q;
    assign out_if.l2_rsp_out_id        = rsp_id_q;
    assign out_if.l2_rsp_out_addr      = rsp_addr_q;
    assign out_if.l2_rsp_out_line      = rsp_line_q;

    assign out_if.l2_rd_rsp_valid_int  = rd_full_q;
    assign out_if.l2_rd_rsp_line       = rd_line_q;

    assign out_if.l2_inval_valid_int   = inv_cnt_q != 2'd0;
    assign out_if.l2_inval_addr        = inv_mem_q[inv_rd_q];

endmodule
